// File: rtl/frame_hex_uart_tx_pkg.sv
// Shared types and constants for the framed hex-dump UART transmitter.
package frame_hex_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        HI    = 3'd3,
        LO    = 3'd4,
        SEP0  = 3'd5,
        SEP1  = 3'd6
    } state_t;

    localparam int FIFO_W  = 10;
    localparam int EOF_BIT = 9;
    localparam int SOF_BIT = 8;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] SP = 8'h20;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: start bit, data LSB first, stop bit, CLKS_PER_BIT clocks each.
module uart_tx_core
    import frame_hex_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX = 4'd9;

    logic              active_r;
    logic              txd_r;
    logic [8:0]        shift_r;
    logic [3:0]        bit_cnt_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic              last_cycle_s;

    // Busy drops in the final stop-bit clock so the next character can be queued
    // with only one idle clock between frames.
    assign last_cycle_s = (bit_cnt_r == STOP_IDX) && (baud_cnt_r == BAUD_LAST);
    assign busy         = active_r && !last_cycle_s;
    assign txd          = txd_r;

    // Bit timing and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r   <= 1'b0;
            txd_r      <= 1'b1;
            shift_r    <= 9'h000;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= '0;
        end else if (start && !busy) begin
            active_r   <= 1'b1;
            txd_r      <= 1'b0;
            shift_r    <= {1'b1, data};
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= '0;
        end else if (active_r) begin
            if (baud_cnt_r == BAUD_LAST) begin
                baud_cnt_r <= '0;
                if (bit_cnt_r == STOP_IDX) begin
                    active_r <= 1'b0;
                    txd_r    <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    txd_r     <= shift_r[0];
                    shift_r   <= {1'b1, shift_r[8:1]};
                end
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
            end
        end else begin
            txd_r <= 1'b1;
        end
    end

endmodule

// File: rtl/frame_hex_uart_tx.sv
// Prints framed FIFO bytes as uppercase hex pairs on a UART: space separated,
// CR LF at frame end, after BYTES_PER_LINE bytes, and ahead of a frame that starts mid-line.
module frame_hex_uart_tx
    import frame_hex_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int BAUD_RATE      = 115200,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [9:0] fifo_rd_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       uart_txd,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam logic [4:0] LINE_MAX = 5'(BYTES_PER_LINE);

    state_t            state_r;
    state_t            state_next_s;
    logic [FIFO_W-1:0] word_r;
    logic [4:0]        line_cnt_r;
    logic              pre_break_r;
    logic              char_sent_r;
    logic              armed_r;
    logic              rd_en_r;
    logic              tx_start_s;
    logic              tx_busy_s;
    logic [7:0]        tx_char_s;
    logic              char_done_s;
    logic              line_end_s;

    function automatic logic [7:0] nibble_ascii(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h37 + {4'h0, nib};
        end
        return code;
    endfunction

    assign char_done_s = char_sent_r && !tx_busy_s;
    // pre_break_r marks the CR LF inserted before the first byte of a frame that starts mid-line.
    assign line_end_s  = pre_break_r || word_r[EOF_BIT] || (line_cnt_r == LINE_MAX);
    assign fifo_rd_en  = rd_en_r;
    assign busy        = (state_r != IDLE) || tx_busy_s;

    // State register.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (armed_r && !fifo_empty) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: state_next_s = LATCH;
            LATCH: begin
                if (fifo_rd_data[SOF_BIT] && (line_cnt_r != 5'd0)) begin
                    state_next_s = SEP0;
                end else begin
                    state_next_s = HI;
                end
            end
            HI: begin
                if (char_done_s) begin
                    state_next_s = LO;
                end else begin
                    state_next_s = HI;
                end
            end
            LO: begin
                if (char_done_s) begin
                    state_next_s = SEP0;
                end else begin
                    state_next_s = LO;
                end
            end
            SEP0: begin
                if (char_done_s) begin
                    state_next_s = line_end_s ? SEP1 : IDLE;
                end else begin
                    state_next_s = SEP0;
                end
            end
            SEP1: begin
                if (char_done_s) begin
                    state_next_s = pre_break_r ? HI : IDLE;
                end else begin
                    state_next_s = SEP1;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Character selection and serializer start strobe.
    always_comb begin
        tx_char_s  = SP;
        tx_start_s = 1'b0;
        case (state_r)
            HI: begin
                tx_char_s  = nibble_ascii(word_r[7:4]);
                tx_start_s = !char_sent_r;
            end
            LO: begin
                tx_char_s  = nibble_ascii(word_r[3:0]);
                tx_start_s = !char_sent_r;
            end
            SEP0: begin
                tx_char_s  = line_end_s ? CR : SP;
                tx_start_s = !char_sent_r;
            end
            SEP1: begin
                tx_char_s  = LF;
                tx_start_s = !char_sent_r;
            end
            default: begin
                tx_char_s  = SP;
                tx_start_s = 1'b0;
            end
        endcase
    end

    // FIFO handshake, word latch, line counter and per-state send tracking.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            armed_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            word_r      <= 10'h000;
            line_cnt_r  <= 5'd0;
            pre_break_r <= 1'b0;
            char_sent_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            rd_en_r <= (state_r == IDLE) && (state_next_s == FETCH);
            if (state_r == LATCH) begin
                word_r      <= fifo_rd_data;
                pre_break_r <= fifo_rd_data[SOF_BIT] && (line_cnt_r != 5'd0);
            end else if ((state_r == SEP1) && char_done_s) begin
                pre_break_r <= 1'b0;
            end
            if ((state_r == HI) && char_done_s) begin
                line_cnt_r <= (word_r[SOF_BIT] ? 5'd0 : line_cnt_r) + 5'd1;
            end else if ((state_r == SEP1) && char_done_s) begin
                line_cnt_r <= 5'd0;
            end
            if (state_next_s != state_r) begin
                char_sent_r <= 1'b0;
            end else if (tx_start_s && !tx_busy_s) begin
                char_sent_r <= 1'b1;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .start (tx_start_s),
        .data  (tx_char_s),
        .txd   (uart_txd),
        .busy  (tx_busy_s)
    );

endmodule

// File: tb/tb_frame_hex_uart_tx.sv
// Scoreboard bench: a text-level reference model queues expected characters,
// a UART receiver monitor decodes uart_txd and compares.
module tb_frame_hex_uart_tx;

    localparam int CPB = 10;
    localparam int BPL = 16;

    logic       clk_50m      = 1'b0;
    logic       rst_n        = 1'b0;
    logic [9:0] fifo_rd_data = 10'h000;
    logic       fifo_empty   = 1'b1;
    logic       fifo_rd_en;
    logic       uart_txd;
    logic       busy;

    logic [9:0] fifo_q[$];
    logic [7:0] sb[$];
    int         checks     = 0;
    int         errors     = 0;
    int         model_line = 0;
    int         pushed     = 0;
    int         rd_count   = 0;
    logic       prev_rd    = 1'b0;

    frame_hex_uart_tx #(
        .CLK_FREQ_HZ    (1000000),
        .BAUD_RATE      (95000),
        .BYTES_PER_LINE (BPL)
    ) dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .uart_txd     (uart_txd),
        .busy         (busy)
    );

    always #5 clk_50m = ~clk_50m;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return 8'(digits.getc(int'(n)));
    endfunction

    // Text-level model: what a terminal should see for each word.
    task automatic model_word(input logic [9:0] w);
        if (w[8] && model_line != 0) begin
            sb.push_back(8'h0D);
            sb.push_back(8'h0A);
        end
        if (w[8]) model_line = 0;
        sb.push_back(hex_char(w[7:4]));
        sb.push_back(hex_char(w[3:0]));
        model_line++;
        if (w[9] || model_line == BPL) begin
            sb.push_back(8'h0D);
            sb.push_back(8'h0A);
            model_line = 0;
        end else begin
            sb.push_back(8'h20);
        end
    endtask

    task automatic push_raw(input logic [9:0] w);
        fifo_q.push_back(w);
        pushed++;
    endtask

    task automatic send_word(input logic [9:0] w);
        model_word(w);
        push_raw(w);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && fifo_q.size() == 0 && !busy) && n < max_cycles) begin
            @(negedge clk_50m);
            n++;
        end
        check(name, {31'h0, (sb.size() == 0 && !busy)}, 32'h1);
    endtask

    // Standard-read FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk_50m) begin
        if (fifo_rd_en && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Read strobe discipline.
    always @(posedge clk_50m) begin
        if (fifo_rd_en) begin
            check("rd_en_single_cycle", {31'h0, prev_rd}, 32'h0);
            check("rd_en_while_empty", {31'h0, fifo_empty}, 32'h0);
            rd_count <= rd_count + 1;
        end
        prev_rd <= fifo_rd_en;
    end

    // UART receiver monitor.
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] exp_c;
        int         low_len;
        bit         aborted;
        bit         seen_high;
        forever begin
            @(negedge clk_50m);
            if (rst_n === 1'b1 && uart_txd === 1'b0) begin
                bits      = 10'h000;
                low_len   = 0;
                aborted   = 1'b0;
                seen_high = 1'b0;
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k != 0) @(negedge clk_50m);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!seen_high && uart_txd === 1'b1) begin
                        seen_high = 1'b1;
                        low_len   = k;
                    end
                    if (k % CPB == CPB / 2) bits[k / CPB] = uart_txd;
                end
                if (!aborted) begin
                    check("char_expected", {31'h0, sb.size() != 0}, 32'h1);
                    if (sb.size() != 0) begin
                        exp_c = sb.pop_front();
                        check("char", {24'h0, bits[8:1]}, {24'h0, exp_c});
                        check("start_bit", {31'h0, bits[0]}, 32'h0);
                        check("stop_bit", {31'h0, bits[9]}, 32'h1);
                        if (bits[1]) check("start_bit_len", low_len, CPB);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int   n;
        int   len;
        bit   keep_eof;
        logic [9:0] w2;

        repeat (3) @(negedge clk_50m);
        check("reset_txd", {31'h0, uart_txd}, 32'h1);
        check("reset_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_50m);
            check("idle_txd", {31'h0, uart_txd}, 32'h1);
            check("idle_rd_en", {31'h0, fifo_rd_en}, 32'h0);
            check("idle_busy", {31'h0, busy}, 32'h0);
        end

        send_word({1'b1, 1'b1, 8'h3A});
        wait_drain(3000, "drain_single");
        check("single_read_pulses", rd_count, 1);

        for (int i = 0; i < 20; i++) send_word({i == 19, i == 0, 8'(i)});
        wait_drain(20000, "drain_20byte");

        for (int i = 0; i < 3; i++) send_word({i == 2, i == 0, 8'(8'hA0 + i)});
        for (int i = 0; i < 2; i++) send_word({i == 1, i == 0, 8'(8'hB0 + i)});
        wait_drain(8000, "drain_back_to_back");

        for (int i = 0; i < 5; i++) send_word({1'b0, i == 0, 8'(8'h50 + i)});
        for (int i = 0; i < 2; i++) send_word({i == 1, i == 0, 8'(8'hE0 + i)});
        wait_drain(8000, "drain_partial_line");

        for (int f = 0; f < 6; f++) begin
            len      = $urandom_range(1, 18);
            keep_eof = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                send_word({(i == len - 1) && keep_eof, i == 0, 8'($urandom_range(0, 255))});
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 300)) @(negedge clk_50m);
            end
        end
        wait_drain(40000, "drain_random");

        // Reset in the 5th bit of the first character; the second word must print cleanly.
        send_word({1'b1, 1'b1, 8'hC5});
        w2 = {1'b1, 1'b1, 8'h7E};
        push_raw(w2);
        n = 0;
        while (uart_txd && n < 2000) begin
            @(negedge clk_50m);
            n++;
        end
        check("rst_test_start_seen", {31'h0, uart_txd}, 32'h0);
        repeat (4 * CPB + CPB / 2) @(negedge clk_50m);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_txd", {31'h0, uart_txd}, 32'h1);
        check("rst_mid_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        sb.delete();
        model_line = 0;
        model_word(w2);
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        @(posedge clk_50m);
        #1;
        check("first_read_delay", {31'h0, fifo_rd_en}, 32'h0);
        wait_drain(3000, "drain_after_reset");

        check("read_count", rd_count, pushed);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
